// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Grant is combinational in IDLE. Strobes come 1 cycle after mem_resp_valid. mem_req_ok stalls in ISSUE.
module mem_port_arbiter #(
  parameter int xlen          = 32,
  parameter int LS_STREAK_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  input  logic [xlen-1:0] if_req_adr,
  output logic            if_req_ok,
  input  logic            if_flush,
  output logic            if_resp_valid,
  output logic [xlen-1:0] if_resp_data,
  input  logic            ls_req_valid,
  input  logic            ls_req_we,
  input  logic [3:0]      ls_req_be,
  input  logic [xlen-1:0] ls_req_adr,
  input  logic [xlen-1:0] ls_req_wdata,
  output logic            ls_req_ok,
  output logic            ls_resp_valid,
  output logic [xlen-1:0] ls_resp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ok,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [xlen-1:0] mem_adr,
  output logic [xlen-1:0] mem_wdata,
  input  logic            mem_resp_valid,
  input  logic [xlen-1:0] mem_resp_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(LS_STREAK_MAX);

  state_t          state_q, state_d;
  logic            owner_ls_q, owner_ls_d;
  logic [3:0]      ls_streak_q, ls_streak_d;
  logic            drop_q, drop_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [xlen-1:0] mem_adr_q, mem_adr_d;
  logic [xlen-1:0] mem_wdata_q, mem_wdata_d;
  logic            if_resp_valid_q, if_resp_valid_d;
  logic [xlen-1:0] if_resp_data_q, if_resp_data_d;
  logic            ls_resp_valid_q, ls_resp_valid_d;
  logic [xlen-1:0] ls_resp_data_q, ls_resp_data_d;

  logic if_elig;
  logic grant_ls;
  logic grant_if;

  assign if_elig  = if_req_valid && !if_flush;
  assign grant_ls = (state_q == IDLE) && ls_req_valid && !(if_elig && (ls_streak_q == STREAK_MAX));
  assign grant_if = (state_q == IDLE) && !grant_ls && if_elig;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign ls_req_ok = rst_n && grant_ls;
  assign if_req_ok = rst_n && grant_if;

  always_comb begin
    state_d         = state_q;
    owner_ls_d      = owner_ls_q;
    ls_streak_d     = ls_streak_q;
    drop_d          = drop_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_be_d        = mem_be_q;
    mem_adr_d       = mem_adr_q;
    mem_wdata_d     = mem_wdata_q;
    if_resp_valid_d = 1'b0;
    if_resp_data_d  = if_resp_data_q;
    ls_resp_valid_d = 1'b0;
    ls_resp_data_d  = ls_resp_data_q;

    case (state_q)
      IDLE: begin
        if (grant_ls || grant_if) begin
          state_d         = ISSUE;
          owner_ls_d      = grant_ls;
          mem_req_valid_d = 1'b1;
          mem_we_d        = grant_ls ? ls_req_we : 1'b0;
          mem_be_d        = grant_ls ? ls_req_be : 4'hF;
          mem_adr_d       = grant_ls ? ls_req_adr : if_req_adr;
          mem_wdata_d     = grant_ls ? ls_req_wdata : '0;
        end
        if (grant_ls && if_elig) begin
          ls_streak_d = (ls_streak_q == STREAK_MAX) ? ls_streak_q : ls_streak_q + 4'd1;
        end else begin
          ls_streak_d = 4'd0;
        end
      end
      ISSUE: begin
        if (!owner_ls_q && if_flush) drop_d = 1'b1;
        if (mem_req_ok) begin
          state_d         = WAIT;
          mem_req_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (!owner_ls_q && if_flush) drop_d = 1'b1;
        if (mem_resp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (owner_ls_q) begin
            ls_resp_valid_d = 1'b1;
            ls_resp_data_d  = mem_we_q ? '0 : mem_resp_data;
          // A flush arriving together with the response still kills it.
          end else if (!(drop_q || if_flush)) begin
            if_resp_valid_d = 1'b1;
            if_resp_data_d  = mem_resp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      owner_ls_q      <= 1'b0;
      ls_streak_q     <= 4'd0;
      drop_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= 4'd0;
      mem_adr_q       <= '0;
      mem_wdata_q     <= '0;
      if_resp_valid_q <= 1'b0;
      if_resp_data_q  <= '0;
      ls_resp_valid_q <= 1'b0;
      ls_resp_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      owner_ls_q      <= owner_ls_d;
      ls_streak_q     <= ls_streak_d;
      drop_q          <= drop_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_be_q        <= mem_be_d;
      mem_adr_q       <= mem_adr_d;
      mem_wdata_q     <= mem_wdata_d;
      if_resp_valid_q <= if_resp_valid_d;
      if_resp_data_q  <= if_resp_data_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      ls_resp_data_q  <= ls_resp_data_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = mem_be_q;
  assign mem_adr       = mem_adr_q;
  assign mem_wdata     = mem_wdata_q;
  assign if_resp_valid = if_resp_valid_q;
  assign if_resp_data  = if_resp_data_q;
  assign ls_resp_valid = ls_resp_valid_q;
  assign ls_resp_data  = ls_resp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int XLEN  = 32;
  localparam int LSMAX = 4;

  logic            clk;
  logic            rst_n;
  logic            if_req_valid;
  logic [XLEN-1:0] if_req_adr;
  logic            if_req_ok;
  logic            if_flush;
  logic            if_resp_valid;
  logic [XLEN-1:0] if_resp_data;
  logic            ls_req_valid;
  logic            ls_req_we;
  logic [3:0]      ls_req_be;
  logic [XLEN-1:0] ls_req_adr;
  logic [XLEN-1:0] ls_req_wdata;
  logic            ls_req_ok;
  logic            ls_resp_valid;
  logic [XLEN-1:0] ls_resp_data;
  logic            mem_req_valid;
  logic            mem_req_ok;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_adr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.xlen(XLEN), .LS_STREAK_MAX(LSMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_adr(if_req_adr), .if_req_ok(if_req_ok),
    .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_be(ls_req_be),
    .ls_req_adr(ls_req_adr), .ls_req_wdata(ls_req_wdata), .ls_req_ok(ls_req_ok),
    .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ok(mem_req_ok), .mem_we(mem_we),
    .mem_be(mem_be), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_if_ok"}, if_req_ok, 0);
    chk({tag, "_ls_ok"}, ls_req_ok, 0);
    chk({tag, "_if_rv"}, if_resp_valid, 0);
    chk({tag, "_if_rd"}, if_resp_data, 0);
    chk({tag, "_ls_rv"}, ls_resp_valid, 0);
    chk({tag, "_ls_rd"}, ls_resp_data, 0);
    chk({tag, "_mvalid"}, mem_req_valid, 0);
    chk({tag, "_mwe"}, mem_we, 0);
    chk({tag, "_mbe"}, mem_be, 0);
    chk({tag, "_madr"}, mem_adr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
  endtask

  // Transaction-level reference model state for the random phase
  bit              m_if_v, m_ls_v, m_ls_we;
  logic [XLEN-1:0] m_if_a, m_ls_a, m_ls_wd;
  logic [3:0]      m_ls_be;
  bit              m_busy, m_t_ls, m_t_we, m_t_drop;
  logic [3:0]      m_t_be;
  logic [XLEN-1:0] m_t_adr, m_t_wd;
  int              m_phase, m_wait, m_run;
  bit              m_due_if, m_due_ls;
  logic [XLEN-1:0] m_if_data, m_ls_data;
  bit              r_flush, free, elig, e_ls, e_if;
  bit              exp_ls_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    rst_n = 1'b0; if_req_valid = 0; if_req_adr = '0; if_flush = 0;
    ls_req_valid = 0; ls_req_we = 0; ls_req_be = '0; ls_req_adr = '0; ls_req_wdata = '0;
    mem_req_ok = 0; mem_resp_valid = 0; mem_resp_data = '0;
    repeat (3) @(negedge clk);
    #2 zero_chk("rst");
    @(negedge clk); rst_n = 1'b1;

    // IF only fetch
    @(negedge clk); if_req_valid = 1; if_req_adr = 32'h100;
    #2 chk("t1_if_ok", if_req_ok, 1); chk("t1_ls_ok", ls_req_ok, 0);
    @(negedge clk); if_req_valid = 0; mem_req_ok = 1;
    #2 chk("t1_mvalid", mem_req_valid, 1); chk("t1_madr", mem_adr, 32'h100);
    chk("t1_mbe", mem_be, 4'hF); chk("t1_mwe", mem_we, 0);
    @(negedge clk); mem_req_ok = 0; mem_resp_valid = 1; mem_resp_data = 32'h00A00093;
    #2 chk("t1_mvalid_off", mem_req_valid, 0); chk("t1_rv_early", if_resp_valid, 0);
    @(negedge clk); mem_resp_valid = 0;
    #2 chk("t1_rv", if_resp_valid, 1); chk("t1_rd", if_resp_data, 32'h00A00093);
    @(negedge clk);
    #2 chk("t1_rv_pulse", if_resp_valid, 0); chk("t1_rd_hold", if_resp_data, 32'h00A00093);

    // Store
    @(negedge clk); ls_req_valid = 1; ls_req_we = 1; ls_req_be = 4'b0011;
    ls_req_adr = 32'h2000; ls_req_wdata = 32'hBEEF;
    #2 chk("t2_ls_ok", ls_req_ok, 1);
    @(negedge clk); ls_req_valid = 0; mem_req_ok = 1;
    #2 chk("t2_mwe", mem_we, 1); chk("t2_mbe", mem_be, 4'b0011);
    chk("t2_madr", mem_adr, 32'h2000); chk("t2_mwdata", mem_wdata, 32'hBEEF);
    @(negedge clk); mem_req_ok = 0; mem_resp_valid = 1; mem_resp_data = 32'hFFFF_FFFF;
    @(negedge clk); mem_resp_valid = 0;
    #2 chk("t2_rv", ls_resp_valid, 1); chk("t2_rd", ls_resp_data, 0);
    @(negedge clk);
    #2 chk("t2_rv_pulse", ls_resp_valid, 0);

    // Contention with streak limit
    @(negedge clk); ls_req_valid = 1; ls_req_we = 0; ls_req_be = 4'hF; ls_req_adr = 32'h3000;
    if_req_valid = 1; if_req_adr = 32'h200; mem_req_ok = 1; mem_resp_valid = 1;
    mem_resp_data = 32'h33;
    #2;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        repeat (3) @(negedge clk);
        #2;
      end
      chk($sformatf("t3_grant%0d", k), {ls_req_ok, if_req_ok},
          exp_ls_seq[k] ? 32'd2 : 32'd1);
    end
    @(negedge clk); ls_req_valid = 0; if_req_valid = 0;
    repeat (2) @(negedge clk);
    mem_req_ok = 0; mem_resp_valid = 0;
    #2 chk("t3_last_if_rv", if_resp_valid, 1);

    // Flush while waiting
    @(negedge clk); if_req_valid = 1; if_req_adr = 32'h300;
    #2 chk("t4_if_ok", if_req_ok, 1);
    @(negedge clk); if_req_valid = 0; mem_req_ok = 1;
    #2 chk("t4_mvalid", mem_req_valid, 1);
    @(negedge clk); mem_req_ok = 0; if_flush = 1;
    #2 chk("t4_wait", mem_req_valid, 0);
    @(negedge clk); if_flush = 0; mem_resp_valid = 1; mem_resp_data = 32'hDEAD0001;
    @(negedge clk); mem_resp_valid = 0; if_req_valid = 1; if_req_adr = 32'h304;
    #2 chk("t4_dropped", if_resp_valid, 0); chk("t4_rd_hold", if_resp_data, 32'h33);
    chk("t4_regrant", if_req_ok, 1);
    @(negedge clk); if_req_valid = 0; mem_req_ok = 1;
    #2 chk("t4_madr", mem_adr, 32'h304);
    @(negedge clk); mem_req_ok = 0; mem_resp_valid = 1; mem_resp_data = 32'h1234;
    @(negedge clk); mem_resp_valid = 0;
    #2 chk("t4_rv", if_resp_valid, 1); chk("t4_rd", if_resp_data, 32'h1234);

    // mem_req_ok backpressure
    @(negedge clk); ls_req_valid = 1; ls_req_we = 0; ls_req_be = 4'hF; ls_req_adr = 32'h400;
    #2 chk("t5_ls_ok", ls_req_ok, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); ls_req_adr = 32'h404; if_req_valid = 1; if_req_adr = 32'h500;
      #2 chk("t5_mvalid", mem_req_valid, 1); chk("t5_madr", mem_adr, 32'h400);
      chk("t5_mbe", mem_be, 4'hF); chk("t5_mwe", mem_we, 0);
      chk("t5_no_ok", {ls_req_ok, if_req_ok}, 0);
    end
    @(negedge clk); ls_req_valid = 0; if_req_valid = 0; mem_req_ok = 1;
    #2 chk("t5_mvalid_end", mem_req_valid, 1);
    @(negedge clk); mem_req_ok = 0; mem_resp_valid = 1; mem_resp_data = 32'h5555;
    @(negedge clk); mem_resp_valid = 0;
    #2 chk("t5_rv", ls_resp_valid, 1); chk("t5_rd", ls_resp_data, 32'h5555);

    // Reset in WAIT
    @(negedge clk); if_req_valid = 1; if_req_adr = 32'h600;
    #2 chk("t6_if_ok", if_req_ok, 1);
    @(negedge clk); if_req_valid = 0; mem_req_ok = 1;
    @(negedge clk); mem_req_ok = 0; rst_n = 0;
    @(negedge clk); rst_n = 1; mem_resp_valid = 1; mem_resp_data = 32'h66;
    #2 zero_chk("t6");
    @(negedge clk); mem_resp_valid = 0; ls_req_valid = 1; ls_req_adr = 32'h700;
    #2 chk("t6_no_if_rv", if_resp_valid, 0); chk("t6_no_ls_rv", ls_resp_valid, 0);
    chk("t6_idle", ls_req_ok, 1);
    @(negedge clk); ls_req_valid = 0; rst_n = 0;
    @(negedge clk); rst_n = 1;

    // Randomized run
    m_if_v = 0; m_ls_v = 0; m_busy = 0; m_run = 0; m_due_if = 0; m_due_ls = 0;
    m_if_data = '0; m_ls_data = '0; m_phase = 0; m_wait = 0; m_t_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!m_if_v && $urandom_range(0, 2) == 0) begin
        m_if_v = 1; m_if_a = $urandom;
      end
      if (!m_ls_v && $urandom_range(0, 1) == 0) begin
        m_ls_v = 1; m_ls_we = 1'($urandom_range(0, 1)); m_ls_be = 4'($urandom);
        m_ls_a = $urandom; m_ls_wd = $urandom;
      end
      r_flush = ($urandom_range(0, 7) == 0);
      if_req_valid = m_if_v; if_req_adr = m_if_a; if_flush = r_flush;
      ls_req_valid = m_ls_v; ls_req_we = m_ls_we; ls_req_be = m_ls_be;
      ls_req_adr = m_ls_a; ls_req_wdata = m_ls_wd;
      mem_req_ok = ($urandom_range(0, 2) != 0);
      if (m_busy && m_phase == 2) mem_resp_valid = (m_wait == 0);
      else mem_resp_valid = ($urandom_range(0, 3) == 0);
      mem_resp_data = $urandom;
      #2;
      free = !m_busy;
      elig = m_if_v && !r_flush;
      e_ls = free && m_ls_v && !(elig && m_run == LSMAX);
      e_if = free && !e_ls && elig;
      chk("r_ls_ok", ls_req_ok, e_ls);
      chk("r_if_ok", if_req_ok, e_if);
      chk("r_mvalid", mem_req_valid, m_busy && m_phase == 1);
      if (m_busy && m_phase == 1) begin
        chk("r_madr", mem_adr, m_t_adr);
        chk("r_mwe", mem_we, m_t_we);
        chk("r_mbe", mem_be, m_t_be);
        if (m_t_ls) chk("r_mwdata", mem_wdata, m_t_wd);
      end
      chk("r_if_rv", if_resp_valid, m_due_if);
      chk("r_if_rd", if_resp_data, m_if_data);
      chk("r_ls_rv", ls_resp_valid, m_due_ls);
      chk("r_ls_rd", ls_resp_data, m_ls_data);

      m_due_if = 0; m_due_ls = 0;
      if (m_busy) begin
        if (!m_t_ls && r_flush) m_t_drop = 1;
        if (m_phase == 1) begin
          if (mem_req_ok) begin
            m_phase = 2; m_wait = $urandom_range(0, 3);
          end
        end else if (mem_resp_valid) begin
          m_busy = 0;
          if (m_t_ls) begin
            m_due_ls = 1; m_ls_data = m_t_we ? '0 : mem_resp_data;
          end else if (!m_t_drop) begin
            m_due_if = 1; m_if_data = mem_resp_data;
          end
        end else begin
          m_wait--;
        end
      end
      if (e_ls) begin
        m_busy = 1; m_phase = 1; m_t_ls = 1; m_t_drop = 0; m_t_we = m_ls_we;
        m_t_be = m_ls_be; m_t_adr = m_ls_a; m_t_wd = m_ls_wd; m_ls_v = 0;
        m_run = elig ? m_run + 1 : 0;
      end else if (e_if) begin
        m_busy = 1; m_phase = 1; m_t_ls = 0; m_t_drop = 0; m_t_we = 0;
        m_t_be = 4'hF; m_t_adr = m_if_a; m_if_v = 0; m_run = 0;
      end else if (free) begin
        m_run = 0;
      end
      if (r_flush && m_if_v && $urandom_range(0, 1) == 0) m_if_v = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single memory port between two requesters: instruction fetch (IF) and load/store unit (LS).
- Sits between ifetch / the LSU and the external memory interface; it replaces the direct ifetch-to-memory address connection.
- Single outstanding transaction. LS has priority, with an anti-starvation streak limit for IF.
- Drops IF responses invalidated by a pipeline flush.

Parameters:
- xlen, 32, data and address width.
- LS_STREAK_MAX, 4, max consecutive LS grants while IF is waiting; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req_valid  in  1  IF request pending
- if_req_adr  in  xlen  IF fetch address
- if_req_ok  out  1  IF request accepted this cycle
- if_flush  in  1  discard in-flight or pending IF request
- if_resp_valid  out  1  IF response strobe
- if_resp_data  out  xlen  fetched word
- ls_req_valid  in  1  LS request pending
- ls_req_we  in  1  1 = store, 0 = load
- ls_req_be  in  4  byte enables
- ls_req_adr  in  xlen  LS address
- ls_req_wdata  in  xlen  store data
- ls_req_ok  out  1  LS request accepted this cycle
- ls_resp_valid  out  1  LS completion strobe (loads and stores)
- ls_resp_data  out  xlen  load data; 0 for stores
- mem_req_valid  out  1  memory request
- mem_req_ok  in  1  memory accepts request
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_adr  out  xlen  address
- mem_wdata  out  xlen  write data
- mem_resp_valid  in  1  memory response strobe
- mem_resp_data  in  xlen  read data

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; owner=IF; ls_streak=0; drop=0.
  - All outputs 0, including the mem_* fields.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Request acceptance: if_req_ok / ls_req_ok are combinational, asserted only in IDLE for the granted requester.
  - A transfer occurs on valid && ok.
  - Grant rule (in order):
    - If ls_req_valid and not (if_req_valid && !if_flush && ls_streak==LS_STREAK_MAX), grant LS.
    - Else if if_req_valid && !if_flush, grant IF.
    - Else no grant.
  - On grant:
    - Latch adr/we/be/wdata; for IF, we=0 and be=4'hF.
    - Set owner; go to ISSUE.
  - Streak counter:
    - LS grant while IF is eligible (if_req_valid && !if_flush): ls_streak+1, saturating.
    - IF grant, or IF not eligible: ls_streak=0.
- ISSUE:
  - mem_req_valid=1 with latched fields held stable.
  - On mem_req_ok: go to WAIT; mem_req_valid deasserts next cycle.
  - mem_resp_valid in ISSUE is ignored.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid, next cycle (1-cycle registered latency):
    - owner=LS: ls_resp_valid=1; ls_resp_data = we ? 0 : mem_resp_data.
    - owner=IF && !drop: if_resp_valid=1; if_resp_data=mem_resp_data.
    - owner=IF && drop: no strobe.
  - State returns to IDLE in that same next cycle, so a new grant can occur the cycle the response strobe is high.
- Flush:
  - if_flush=1 with owner=IF in ISSUE or WAIT sets drop. The memory transaction still completes (no cancel).
  - drop clears when returning to IDLE.
  - if_flush in IDLE blocks the IF grant for that cycle only.
  - if_flush has no effect on LS transactions.
- Response strobes are single-cycle pulses. Data outputs hold their last value otherwise.
- Simultaneous LS and IF valid with streak below max: LS wins.
- Reset mid-transaction: abandons it. No response strobe is generated for it, even if mem_resp_valid arrives later.

Test Plan:
1. IF only:
   - Stimulus: if_req_adr=0x100, mem_req_ok same cycle as ISSUE, mem_resp_data=0x00A00093 two cycles later.
   - Required: if_req_ok in cycle 0; mem_adr=0x100, mem_be=4'hF; if_resp_valid one cycle after mem_resp_valid, data 0x00A00093.
2. Store:
   - Stimulus: ls_req_we=1, be=4'b0011, adr=0x2000, wdata=0xBEEF.
   - Required: mem_we=1, mem_be=4'b0011, mem_wdata=0xBEEF; ls_resp_valid pulse with data 0.
3. Contention:
   - Stimulus: both requesters valid continuously, LS_STREAK_MAX=4, memory answers in 1 cycle.
   - Required: grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
4. Flush in WAIT:
   - Stimulus: IF transaction outstanding; pulse if_flush; memory responds.
   - Required: no if_resp_valid; next if_req_valid is granted normally and its response is delivered.
5. mem_req_ok backpressure:
   - Stimulus: hold mem_req_ok=0 for 5 cycles during ISSUE.
   - Required: mem_req_valid and fields stable for all 5 cycles; no new if_req_ok or ls_req_ok issued.
6. Reset:
   - Stimulus: assert rst_n=0 in WAIT, then release and drive mem_resp_valid.
   - Required: all outputs 0; no response strobe; state IDLE.
